wb_regfile: RTL and testbench

- Write-back end of the MEM/WB pipeline register, plus the integer register file it writes into.
- Selects the write-back value (load data or ALU address/result) using the WB-stage control bits. Commits that value to a 32-entry register file.
- Serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass, so no separate write-first/read-second clock phasing is needed.
- Also provides a debug read port and a retired-write counter for simulation checking.

---
 rtl/wb_regfile.sv | 75 +++++++
 tb/tb_wb_regfile.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage of the MEM/WB register plus the 32-entry integer register file.
// Two combinational ID read ports with same-cycle write bypass, a raw debug port and a retired-write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              RegWrite_WB,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] ReadData_WB,
  input  logic [DATA_W-1:0] Address_WB,
  input  logic [ADDR_W-1:0] rtd_WB,
  input  logic [ADDR_W-1:0] rs_ID,
  input  logic [ADDR_W-1:0] rt_ID,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;
  logic              commit;

  assign wb_data = MemtoReg ? ReadData_WB : Address_WB;

  // An X on RegWrite_WB makes commit X, which every if below treats as false.
  assign commit = (RegWrite_WB == 1'b1) && (rtd_WB != '0) && !reset;

  // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      regs_d[rtd_WB] = wb_data;
      wr_count_d     = wr_count_q + CNT_W'(1);
    end
  end

  // NOTE: the array is reset explicitly because architectural state must read as zero after reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    rs_data = regs_q[rs_ID];
    if (rs_ID == '0)                      rs_data = '0;
    else if (commit && (rs_ID == rtd_WB)) rs_data = wb_data;
  end

  always_comb begin
    rt_data = regs_q[rt_ID];
    if (rt_ID == '0)                      rt_data = '0;
    else if (commit && (rt_ID == rtd_WB)) rt_data = wb_data;
  end

  // Index 0 is never written, so the raw array already reads zero there.
  assign dbg_data = regs_q[dbg_addr];
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; counter narrowed to 4 bits to exercise wrap.
module tb_wb_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              RegWrite_WB, MemtoReg;
  logic [DATA_W-1:0] ReadData_WB, Address_WB;
  logic [ADDR_W-1:0] rtd_WB, rs_ID, rt_ID, dbg_addr;
  logic [DATA_W-1:0] rs_data, rt_data, wb_data, dbg_data;
  logic [CNT_W-1:0]  wr_count;

  int total = 0;
  int bad   = 0;

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .RegWrite_WB(RegWrite_WB), .MemtoReg(MemtoReg),
    .ReadData_WB(ReadData_WB), .Address_WB(Address_WB), .rtd_WB(rtd_WB),
    .rs_ID(rs_ID), .rt_ID(rt_ID), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_reg(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] val);
    RegWrite_WB = 1'b1; MemtoReg = 1'b0; Address_WB = val; rtd_WB = idx;
    tick();
    RegWrite_WB = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; RegWrite_WB = 1'b0; MemtoReg = 1'b0;
    ReadData_WB = '0; Address_WB = '0; rtd_WB = '0;
    rs_ID = '0; rt_ID = '0; dbg_addr = '0;
    #1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      rs_ID = ADDR_W'(i); rt_ID = ADDR_W'(31 - i); dbg_addr = ADDR_W'(i);
      #1;
      check($sformatf("rst_rs[%0d]", i), rs_data, 32'h0);
      check($sformatf("rst_rt[%0d]", 31 - i), rt_data, 32'h0);
      check($sformatf("rst_dbg[%0d]", i), dbg_data, 32'h0);
    end
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'd0);

    // Plain write then register 0 write is dropped
    write_reg(5'd8, 32'h0000_1234);
    rs_ID = 5'd8; dbg_addr = 5'd8;
    #1;
    check("r8_rs", rs_data, 32'h0000_1234);
    check("r8_dbg", dbg_data, 32'h0000_1234);
    check("r8_cnt", 32'(wr_count), 32'd1);

    RegWrite_WB = 1'b1; rtd_WB = 5'd0; Address_WB = 32'hFFFF_FFFF; rs_ID = 5'd0;
    #1;
    check("r0_no_bypass", rs_data, 32'h0);
    tick();
    RegWrite_WB = 1'b0; dbg_addr = 5'd0;
    #1;
    check("r0_dbg", dbg_data, 32'h0);
    check("r0_cnt", 32'(wr_count), 32'd1);

    // MemtoReg selects load data
    RegWrite_WB = 1'b1; MemtoReg = 1'b1; ReadData_WB = 32'hDEAD_BEEF;
    Address_WB = 32'h1; rtd_WB = 5'd31;
    #1;
    check("m2r_wb_data", wb_data, 32'hDEAD_BEEF);
    MemtoReg = 1'b0;
    #1;
    check("alu_wb_data", wb_data, 32'h0000_0001);
    MemtoReg = 1'b1;
    tick();
    RegWrite_WB = 1'b0; MemtoReg = 1'b0; dbg_addr = 5'd31; rt_ID = 5'd31;
    #1;
    check("r31_dbg", dbg_data, 32'hDEAD_BEEF);
    check("r31_rt", rt_data, 32'hDEAD_BEEF);
    check("r31_cnt", 32'(wr_count), 32'd2);

    // Same-cycle bypass on both ports, debug port stays raw
    write_reg(5'd5, 32'hAAAA_AAAA);
    RegWrite_WB = 1'b1; rtd_WB = 5'd5; Address_WB = 32'h5555_5555;
    rs_ID = 5'd5; rt_ID = 5'd5; dbg_addr = 5'd5;
    #1;
    check("byp_rs", rs_data, 32'h5555_5555);
    check("byp_rt", rt_data, 32'h5555_5555);
    check("byp_dbg_raw", dbg_data, 32'hAAAA_AAAA);
    rt_ID = 5'd8;
    #1;
    check("byp_rt_other", rt_data, 32'h0000_1234);
    RegWrite_WB = 1'b0; rt_ID = 5'd5;
    #1;
    check("nobyp_rs", rs_data, 32'hAAAA_AAAA);
    check("nobyp_rt", rt_data, 32'hAAAA_AAAA);
    tick();
    check("nobyp_hold", dbg_data, 32'hAAAA_AAAA);
    check("nobyp_cnt", 32'(wr_count), 32'd3);

    // Reset beats a simultaneous write and suppresses bypass
    write_reg(5'd9, 32'h0000_0077);
    reset = 1'b1; RegWrite_WB = 1'b1; rtd_WB = 5'd9; Address_WB = 32'h0000_0099;
    rs_ID = 5'd9; dbg_addr = 5'd9;
    #1;
    check("rstcyc_rs", rs_data, 32'h0000_0077);
    check("rstcyc_dbg", dbg_data, 32'h0000_0077);
    tick();
    reset = 1'b0; RegWrite_WB = 1'b0;
    #1;
    check("postrst_dbg9", dbg_data, 32'h0);
    check("postrst_rs9", rs_data, 32'h0);
    check("postrst_cnt", 32'(wr_count), 32'd0);
    dbg_addr = 5'd31;
    #1;
    check("postrst_dbg31", dbg_data, 32'h0);

    // Counter wraps at 16 with idle cycles interleaved
    for (int i = 1; i <= 17; i++) begin
      write_reg(ADDR_W'((i % 31) + 1), 32'h100 + 32'(i));
      tick();
      if (i == 3)  check("wrap_idle3", 32'(wr_count), 32'd3);
      if (i == 15) check("wrap_15", 32'(wr_count), 32'd15);
      if (i == 16) check("wrap_16", 32'(wr_count), 32'd0);
    end
    check("wrap_17", 32'(wr_count), 32'd1);
    dbg_addr = 5'd18; rs_ID = 5'd2;
    #1;
    check("wrap_last_reg", dbg_data, 32'h0000_0111);
    check("wrap_first_reg", rs_data, 32'h0000_0101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
